// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard stall controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] NO_STALL   = 2'd0;
  localparam logic [1:0] LU         = 2'd1;
  localparam logic [1:0] LU_BRANCH  = 2'd2;
  localparam logic [1:0] BRANCH_DEP = 2'd1;

  function automatic logic [1:0] max_len(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-length detector: how many bubbles the instruction in ID
// needs for dependences that ID/EX forwarding cannot resolve.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  input  logic                  branch,
  input  logic                  id_ex_memread,
  input  logic                  id_ex_regwrite,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_mem_memread,
  input  logic                  ex_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic [1:0]            n_len
);

  logic rt_read_s;
  logic rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
  logic ex_hit_s, mem_hit_s;

  // Register $0 never carries a dependence; rt only counts when actually read.
  assign rt_read_s = uses_rt | branch;
  assign rs_ex_s   = (rs != {REG_ADDR_W{1'b0}}) && (rs == id_ex_rd);
  assign rt_ex_s   = rt_read_s && (rt != {REG_ADDR_W{1'b0}}) && (rt == id_ex_rd);
  assign rs_mem_s  = (rs != {REG_ADDR_W{1'b0}}) && (rs == ex_mem_rd);
  assign rt_mem_s  = rt_read_s && (rt != {REG_ADDR_W{1'b0}}) && (rt == ex_mem_rd);
  assign ex_hit_s  = rs_ex_s | rt_ex_s;
  assign mem_hit_s = rs_mem_s | rt_mem_s;

  // Stall length is the worst case over all unforwardable dependences.
  always_comb begin
    n_len = NO_STALL;
    if (id_ex_memread && ex_hit_s) begin
      n_len = max_len(n_len, branch ? LU_BRANCH : LU);
    end else begin
      n_len = n_len;
    end
    if (branch && id_ex_regwrite && !id_ex_memread && ex_hit_s) begin
      n_len = max_len(n_len, BRANCH_DEP);
    end else begin
      n_len = n_len;
    end
    if (branch && ex_mem_memread && mem_hit_s) begin
      n_len = max_len(n_len, BRANCH_DEP);
    end else begin
      n_len = n_len;
    end
    // rs can take the EX/MEM ALU value in ID, rt cannot.
    if (branch && ex_mem_regwrite && !ex_mem_memread && rt_mem_s) begin
      n_len = max_len(n_len, BRANCH_DEP);
    end else begin
      n_len = n_len;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall controller: stall FSM, MemBusy freeze and output muxing.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic                  ID_UsesRt,
  input  logic                  ID_Branch,
  input  logic                  ID_BranchTaken,
  input  logic                  ID_Jump,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  EX_MEM_MemRead,
  input  logic                  EX_MEM_RegWrite,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  MemBusy,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Flush,
  output logic                  IF_ID_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     StallCycles
`endif
);

  logic [1:0] n_s;
  state_e     state_q, state_d, adv_state_s;
  logic [1:0] rem_q, rem_d, adv_rem_s;
  logic       stall_s;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .rs              (IF_ID_rs),
    .rt              (IF_ID_rt),
    .uses_rt         (ID_UsesRt),
    .branch          (ID_Branch),
    .id_ex_memread   (ID_EX_MemRead),
    .id_ex_regwrite  (ID_EX_RegWrite),
    .id_ex_rd        (ID_EX_rd),
    .ex_mem_memread  (EX_MEM_MemRead),
    .ex_mem_regwrite (EX_MEM_RegWrite),
    .ex_mem_rd       (EX_MEM_rd),
    .n_len           (n_s)
  );

  // FSM advance as if the pipeline were moving; detection only happens in IDLE.
  always_comb begin
    adv_state_s = state_q;
    adv_rem_s   = rem_q;
    stall_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ID_Valid && (n_s != NO_STALL)) begin
          stall_s = 1'b1;
          if (n_s == LU_BRANCH) begin
            adv_state_s = STALL;
            adv_rem_s   = n_s - 2'd1;
          end else begin
            adv_state_s = IDLE;
            adv_rem_s   = 2'd0;
          end
        end else begin
          adv_state_s = IDLE;
          adv_rem_s   = 2'd0;
        end
      end
      STALL: begin
        stall_s = 1'b1;
        if (rem_q <= 2'd1) begin
          adv_state_s = IDLE;
          adv_rem_s   = 2'd0;
        end else begin
          adv_state_s = STALL;
          adv_rem_s   = rem_q - 2'd1;
        end
      end
      default: begin
        adv_state_s = IDLE;
        adv_rem_s   = 2'd0;
      end
    endcase
  end

  // A memory wait freezes the FSM so the remaining stall resumes intact.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (MemBusy) begin
      state_d = state_q;
      rem_d   = rem_q;
    end else begin
      state_d = adv_state_s;
      rem_d   = adv_rem_s;
    end
  end

  // State and remaining-cycle registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Output mux; redirects are dropped while stalling because operands are stale.
  always_comb begin
    PC_Write    = 1'b0;
    IF_ID_Write = 1'b0;
    ID_EX_Flush = 1'b0;
    IF_ID_Flush = 1'b0;
    if (!reset || MemBusy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b0;
      IF_ID_Flush = 1'b0;
    end else if (stall_s) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      IF_ID_Flush = 1'b0;
    end else begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      ID_EX_Flush = 1'b0;
      IF_ID_Flush = ID_BranchTaken | ID_Jump;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles that actually inserted a bubble.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!MemBusy && stall_s && (stall_cycles_q != {STAT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= {STAT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;
`else
  // Statistics counter not built.
`endif

endmodule
